dmem_bus_arbiter: RTL and testbench

//  Shares the MIPS_SCP data-side memories (dmem window 0x10010000, heap_ram window 0x10000000)

---
 rtl/mips_mem_pkg.sv | 23 ++
 rtl/mem_window_decode.sv | 34 +++
 rtl/dmem_bus_arbiter.sv | 164 ++++++++++++++++
 tb/tb_dmem_bus_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS_SCP data-side memory arbiter.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_RESP
  } arb_state_e;

  typedef enum logic {
    MST_M0 = 1'b0,
    MST_M1 = 1'b1
  } mst_id_e;

  localparam logic [31:0] DMEM_BASE_DEF = 32'h1001_0000;
  localparam logic [31:0] HMEM_BASE_DEF = 32'h1000_0000;

  // Word offset of a byte address from a window base; byte-lane bits are ignored.
  function automatic logic [29:0] word_offset(input logic [31:0] addr, input logic [31:0] base);
    return addr[31:2] - base[31:2];
  endfunction

endpackage

// File: rtl/mem_window_decode.sv
// Combinational address decode onto the data RAM and heap RAM windows.
module mem_window_decode
  import mips_mem_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE = DMEM_BASE_DEF,
  parameter logic [31:0] HMEM_BASE = HMEM_BASE_DEF,
  parameter int unsigned AW        = 10
) (
  input  logic [31:0]   addr,
  output logic          hit_d,
  output logic          hit_h,
  output logic          miss,
  output logic [AW-1:0] index
);

  logic [29:0] off_d;
  logic [29:0] off_h;
  logic        in_d;
  logic        in_h;

  assign off_d = word_offset(addr, DMEM_BASE);
  assign off_h = word_offset(addr, HMEM_BASE);

  // Unsigned offset below 2^AW means inside the window; wrap-around covers addr < base.
  assign in_d = ((off_d >> AW) == '0);
  assign in_h = ((off_h >> AW) == '0);

  // Data RAM has priority if a misconfiguration makes the windows overlap.
  assign hit_d = in_d;
  assign hit_h = ~in_d & in_h;
  assign miss  = ~in_d & ~in_h;
  assign index = in_d ? off_d[AW-1:0] : off_h[AW-1:0];

endmodule

// File: rtl/dmem_bus_arbiter.sv
// Two-master arbiter sharing the data RAM and heap RAM: decode, sequence, respond.
module dmem_bus_arbiter
  import mips_mem_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE  = DMEM_BASE_DEF,
  parameter logic [31:0] HMEM_BASE  = HMEM_BASE_DEF,
  parameter int unsigned AW         = 10,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [31:0]   m0_addr,
  input  logic [31:0]   m0_wdata,
  output logic [31:0]   m0_rdata,
  output logic          m0_ack,
  output logic          m0_err,
  output logic          m0_stall,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [31:0]   m1_addr,
  input  logic [31:0]   m1_wdata,
  output logic [31:0]   m1_rdata,
  output logic          m1_ack,
  output logic          m1_err,
  output logic          d_en,
  output logic          d_we,
  output logic [AW-1:0] d_addr,
  output logic [31:0]   d_wdata,
  input  logic [31:0]   d_rdata,
  output logic          h_en,
  output logic          h_we,
  output logic [AW-1:0] h_addr,
  output logic [31:0]   h_wdata,
  input  logic [31:0]   h_rdata
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  arb_state_e    state_q, state_d;
  mst_id_e       owner_q, owner_d;
  logic [31:0]   addr_q, addr_d;
  logic          we_q, we_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   m0_rdata_q, m0_rdata_d;
  logic [31:0]   m1_rdata_q, m1_rdata_d;

  logic          hit_d;
  logic          hit_h;
  logic          miss;
  logic [AW-1:0] index;
  logic [31:0]   resp_data;

  mem_window_decode #(
    .DMEM_BASE (DMEM_BASE),
    .HMEM_BASE (HMEM_BASE),
    .AW        (AW)
  ) u_decode (
    .addr  (addr_q),
    .hit_d (hit_d),
    .hit_h (hit_h),
    .miss  (miss),
    .index (index)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      owner_q    <= MST_M0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      starve_q   <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      starve_q   <= starve_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    starve_d   = starve_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    resp_data  = '0;
    d_en       = 1'b0;
    d_we       = 1'b0;
    h_en       = 1'b0;
    h_we       = 1'b0;
    m0_ack     = 1'b0;
    m0_err     = 1'b0;
    m1_ack     = 1'b0;
    m1_err     = 1'b0;
    d_addr     = index;
    h_addr     = index;
    d_wdata    = wdata_q;
    h_wdata    = wdata_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (!m1_req) starve_d = '0;
        if (m0_req || m1_req) begin
          if (m1_req && (!m0_req || starve_q == STARVE_TOP)) begin
            owner_d  = MST_M1;
            addr_d   = m1_addr;
            we_d     = m1_we;
            wdata_d  = m1_wdata;
            starve_d = '0;
          end else begin
            owner_d = MST_M0;
            addr_d  = m0_addr;
            we_d    = m0_we;
            wdata_d = m0_wdata;
            // Never at the top here: a saturated counter hands the grant to M1 above.
            if (m1_req) starve_d = starve_q + 1'b1;
          end
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        d_en    = hit_d;
        d_we    = hit_d & we_q;
        h_en    = hit_h;
        h_we    = hit_h & we_q;
        state_d = ARB_RESP;
      end
      ARB_RESP: begin
        if (!we_q) resp_data = hit_d ? d_rdata : (hit_h ? h_rdata : '0);
        if (owner_q == MST_M0) begin
          m0_ack     = 1'b1;
          m0_err     = miss;
          m0_rdata_d = resp_data;
        end else begin
          m1_ack     = 1'b1;
          m1_err     = miss;
          m1_rdata_d = resp_data;
        end
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Next-state value is the live response during ack and the held value otherwise.
  assign m0_rdata = m0_rdata_d;
  assign m1_rdata = m1_rdata_d;
  assign m0_stall = m0_req & ~m0_ack;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Scoreboard bench for dmem_bus_arbiter with behavioural RAMs and a window/array reference model.
module tb_dmem_bus_arbiter;

  localparam logic [31:0] DBASE = 32'h1001_0000;
  localparam logic [31:0] HBASE = 32'h1000_0000;
  localparam int unsigned WORDS = 1024;

  typedef struct {
    bit          we;
    bit          err;
    logic [31:0] rdata;
    int          kind;  // 0 none, 1 data RAM, 2 heap RAM
    int          idx;
    logic [31:0] wdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic [31:0] m0_rdata;
  logic        m0_ack, m0_err, m0_stall;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic [31:0] m1_rdata;
  logic        m1_ack, m1_err;
  logic        d_en, d_we, h_en, h_we;
  logic [9:0]  d_addr, h_addr;
  logic [31:0] d_wdata, h_wdata;
  logic [31:0] d_rdata = '0, h_rdata = '0;

  logic [31:0] dram [WORDS] = '{default: '0};
  logic [31:0] hram [WORDS] = '{default: '0};
  logic [31:0] ref_d [WORDS] = '{default: '0};
  logic [31:0] ref_h [WORDS] = '{default: '0};

  exp_t q0[$];
  exp_t q1[$];
  int   ack_log[$];
  int   n_tests = 0;
  int   n_fail = 0;

  dmem_bus_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .m0_req   (m0_req),
    .m0_we    (m0_we),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_rdata (m0_rdata),
    .m0_ack   (m0_ack),
    .m0_err   (m0_err),
    .m0_stall (m0_stall),
    .m1_req   (m1_req),
    .m1_we    (m1_we),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_rdata (m1_rdata),
    .m1_ack   (m1_ack),
    .m1_err   (m1_err),
    .d_en     (d_en),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .h_en     (h_en),
    .h_we     (h_we),
    .h_addr   (h_addr),
    .h_wdata  (h_wdata),
    .h_rdata  (h_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAMs with one-cycle registered read.
  always @(posedge clk) begin
    if (d_en) begin
      if (d_we) dram[d_addr] <= d_wdata;
      d_rdata <= dram[d_addr];
    end
    if (h_en) begin
      if (h_we) hram[h_addr] <= h_wdata;
      h_rdata <= hram[h_addr];
    end
  end

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic exp_t model(input bit we, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    e.we = we; e.wdata = wd; e.err = 1'b0; e.rdata = '0; e.kind = 0; e.idx = 0;
    if (a >= DBASE && a < DBASE + 4 * WORDS) begin
      e.kind = 1; e.idx = int'((a - DBASE) / 4);
      if (we) ref_d[e.idx] = wd; else e.rdata = ref_d[e.idx];
    end else if (a >= HBASE && a < HBASE + 4 * WORDS) begin
      e.kind = 2; e.idx = int'((a - HBASE) / 4);
      if (we) ref_h[e.idx] = wd; else e.rdata = ref_h[e.idx];
    end else begin
      e.err = 1'b1;
    end
    return e;
  endfunction

  task automatic xact(input int m, input bit we, input logic [31:0] a, input logic [31:0] wd,
                      output int lat);
    exp_t e;
    bit   got;
    e = model(we, a, wd);
    if (m == 0) begin
      q0.push_back(e); m0_we = we; m0_addr = a; m0_wdata = wd; m0_req = 1'b1;
    end else begin
      q1.push_back(e); m1_we = we; m1_addr = a; m1_wdata = wd; m1_req = 1'b1;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      got = (m == 0) ? m0_ack : m1_ack;
    end
    if (!got) begin
      n_fail++;
      $display("FAIL ack_timeout: master %0d got no ack after %0d cycles, expected ack", m, lat);
    end
    @(posedge clk);
    #1;
    if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_run(input int m, input int n);
    int          lat;
    int          r;
    int          idx;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      r   = $urandom_range(0, 9);
      idx = 2 * $urandom_range(0, 15) + m;
      if (r == 0)     a = 32'h2000_0000 + ($urandom & 32'h00ff_ffff);
      else if (r < 6) a = DBASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
      else            a = HBASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
      xact(m, $urandom_range(0, 1) == 1, a, $urandom, lat);
      gap($urandom_range(0, 2));
    end
  endtask

  // Monitor: records strobes, pops the scoreboard on every ack, checks protocol invariants.
  initial begin
    exp_t        e;
    int          s_kind;
    int          s_idx;
    bit          s_we;
    logic [31:0] s_wd;
    logic [31:0] last0;
    logic [31:0] last1;
    s_kind = 0; s_idx = 0; s_we = 1'b0; s_wd = '0; last0 = '0; last1 = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        last0 = '0; last1 = '0; s_kind = 0;
        if (m0_ack || m1_ack || d_en || h_en) begin
          n_fail++;
          $display("FAIL reset_quiet: ack/strobe active during reset, expected none");
        end
        continue;
      end
      if (m0_ack && m1_ack) begin
        n_fail++;
        $display("FAIL dual_ack: both acks 1, expected at most one");
      end
      if (d_en && h_en) begin
        n_fail++;
        $display("FAIL dual_strobe: d_en and h_en both 1, expected at most one");
      end
      if (m0_stall !== (m0_req & ~m0_ack)) begin
        n_fail++;
        $display("FAIL m0_stall: got %b, expected %b", m0_stall, m0_req & ~m0_ack);
      end
      if (d_en) begin s_kind = 1; s_idx = int'(d_addr); s_we = d_we; s_wd = d_wdata; end
      if (h_en) begin s_kind = 2; s_idx = int'(h_addr); s_we = h_we; s_wd = h_wdata; end
      for (int m = 0; m < 2; m++) begin
        if ((m == 0) ? m0_ack : m1_ack) begin
          if ((m == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
            n_fail++;
            $display("FAIL unexpected_ack: master %0d acked with empty scoreboard", m);
          end else begin
            e = (m == 0) ? q0.pop_front() : q1.pop_front();
            cmp($sformatf("m%0d_rdata", m), (m == 0) ? m0_rdata : m1_rdata, e.rdata);
            cmp($sformatf("m%0d_err", m), 32'((m == 0) ? m0_err : m1_err), 32'(e.err));
            cmp($sformatf("m%0d_strobe_ram", m), 32'(s_kind), 32'(e.kind));
            if (e.kind != 0) begin
              cmp($sformatf("m%0d_strobe_idx", m), 32'(s_idx), 32'(e.idx));
              cmp($sformatf("m%0d_strobe_we", m), 32'(s_we), 32'(e.we));
              if (e.we) cmp($sformatf("m%0d_strobe_wdata", m), s_wd, e.wdata);
            end
            if (m == 0) last0 = e.rdata; else last1 = e.rdata;
          end
          ack_log.push_back(m);
          s_kind = 0;
        end else begin
          cmp($sformatf("m%0d_rdata_hold", m), (m == 0) ? m0_rdata : m1_rdata,
              (m == 0) ? last0 : last1);
        end
      end
    end
  end

  initial begin
    int lat;
    int exp_order [10];
    int lat0, lat1;

    #95;
    cmp("rst_m0_rdata", m0_rdata, 32'h0);
    cmp("rst_m1_rdata", m1_rdata, 32'h0);
    cmp("rst_acks", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'h0);
    cmp("rst_strobes", 32'({d_en, h_en}), 32'h0);
    #5 reset = 1'b0;
    @(posedge clk);
    #1;

    // Basic write/read on the data RAM with latency check.
    xact(0, 1'b1, 32'h1001_0008, 32'hDEADBEEF, lat);
    cmp("lat_write", 32'(lat), 32'd3);
    xact(0, 1'b0, 32'h1001_0008, 32'h0, lat);
    cmp("lat_read", 32'(lat), 32'd3);

    // Cross-master heap traffic; ignored byte-lane bits on the read.
    xact(1, 1'b1, 32'h1000_0004, 32'h12345678, lat);
    xact(0, 1'b0, 32'h1000_0007, 32'h0, lat);

    // Miss handling, write to miss dropped.
    xact(0, 1'b0, 32'h0040_0000, 32'h0, lat);
    xact(1, 1'b1, 32'h0040_0000, 32'hFFFF_FFFF, lat);

    // Window edges.
    xact(0, 1'b1, DBASE + 4 * (WORDS - 1), 32'hCAFE_F00D, lat);
    xact(0, 1'b0, DBASE + 4 * (WORDS - 1), 32'h0, lat);
    xact(0, 1'b0, DBASE + 4 * WORDS, 32'h0, lat);
    xact(1, 1'b1, HBASE + 4 * (WORDS - 1), 32'h0BEE_F00D, lat);
    xact(1, 1'b0, HBASE + 4 * (WORDS - 1), 32'h0, lat);
    xact(1, 1'b0, HBASE - 4, 32'h0, lat);

    // Starvation: both masters request back to back.
    gap(3);
    ack_log.delete();
    fork
      for (int i = 0; i < 8; i++) xact(0, 1'b0, DBASE + 32'(8 * i), 32'h0, lat0);
      for (int i = 0; i < 2; i++) xact(1, 1'b0, HBASE + 32'(8 * i + 4), 32'h0, lat1);
    join
    exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    cmp("starve_ack_count", 32'(ack_log.size()), 32'd10);
    for (int i = 0; i < 10 && i < ack_log.size(); i++)
      cmp($sformatf("starve_grant_%0d", i), 32'(ack_log[i]), 32'(exp_order[i]));

    // Reset during ISSUE aborts the write.
    xact(0, 1'b1, DBASE + 160, 32'hAAAA5555, lat);
    m0_we = 1'b1; m0_addr = DBASE + 160; m0_wdata = 32'h0BAD0BAD; m0_req = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!d_en && lat < 10);
    cmp("abort_saw_issue", 32'(d_en), 32'd1);
    reset = 1'b1;
    #1;
    cmp("abort_strobes_drop", 32'({d_en, h_en}), 32'h0);
    cmp("abort_m0_rdata", m0_rdata, 32'h0);
    m0_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      cmp("abort_no_ack", 32'({m0_ack, m1_ack}), 32'h0);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    xact(0, 1'b0, DBASE + 160, 32'h0, lat);
    xact(1, 1'b0, 32'h1000_0004, 32'h0, lat);

    // Randomised concurrent traffic; masters use disjoint word indices.
    gap(2);
    fork
      rand_run(0, 60);
      rand_run(1, 60);
    join

    gap(4);
    cmp("q0_drained", 32'(q0.size()), 32'd0);
    cmp("q1_drained", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
